// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: state encoding,
// register-address width and the operand-match helper used by hazard detection.
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_MEM_WAIT = 2'd1,
    CTRL_ABORT    = 2'd2
  } ctrl_state_e;

  // A decode source operand depends on the EX destination register.
  function automatic logic src_hit(input logic                      used,
                                   input logic [REG_ADDR_WIDTH-1:0] src,
                                   input logic [REG_ADDR_WIDTH-1:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments by one per cycle when inc_i is set and
// sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage core: load-use bubbles,
// EX-redirect squashes and data-memory wait freezing with timeout abort.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic                      id_ex_is_load,
  input  logic                      id_ex_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] id_ex_reg_waddr,
  input  logic                      ex_redirect,
  input  logic                      dmem_req,
  input  logic                      dmem_ready,
  output logic                      pc_hold,
  output logic                      if_id_hold,
  output logic                      if_id_flush,
  output logic                      id_ex_hold,
  output logic                      id_ex_flush,
  output logic                      ex_mem_hold,
  output logic [1:0]                ctrl_state,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt,
  output logic                      mem_timeout_err
);

  localparam logic [TO_WIDTH-1:0] TIMEOUT = TO_WIDTH'(MEM_TIMEOUT);

  ctrl_state_e         state_q, state_d;
  logic [TO_WIDTH-1:0] wait_q, wait_d;
  logic                err_q, err_d;
  logic                mem_stall, load_use;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign load_use  = id_ex_is_load & id_ex_reg_wen & (id_ex_reg_waddr != '0) &
                     (src_hit(id_rs1_used, id_rs1_addr, id_ex_reg_waddr) |
                      src_hit(id_rs2_used, id_rs2_addr, id_ex_reg_waddr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CTRL_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      CTRL_RUN: begin
        if (mem_stall) begin
          state_d = CTRL_MEM_WAIT;
          wait_d  = TO_WIDTH'(1);
        end
      end
      CTRL_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = CTRL_RUN;
          wait_d  = '0;
        end else if (wait_q == TIMEOUT) begin
          state_d = CTRL_ABORT;
          wait_d  = '0;
          err_d   = 1'b1;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
      end
      CTRL_ABORT: state_d = CTRL_RUN;
      default: begin
        state_d = CTRL_RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Outputs are forced low while rst_n is asserted, independent of the inputs.
  always_comb begin
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_hold  = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_hold = 1'b0;
    if (rst_n) begin
      case (state_q)
        CTRL_RUN, CTRL_MEM_WAIT: begin
          if ((state_q == CTRL_RUN) ? mem_stall : !dmem_ready) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_hold  = 1'b1;
            ex_mem_hold = 1'b1;
          end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        CTRL_ABORT: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  a_no_hold_and_flush: assert property (@(posedge clk)
    !(if_id_hold && if_id_flush) && !(id_ex_hold && id_ex_flush));

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (pc_hold),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (if_id_flush),
    .cnt_o (flush_cnt)
  );

  assign ctrl_state      = state_q;
  assign mem_timeout_err = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with 4-bit counters and a 4-cycle
// memory timeout; control outputs are packed as {pc,ifid_h,ifid_f,idex_h,idex_f,exmem_h}.
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_ex_reg_waddr;
  logic       id_rs1_used, id_rs2_used, id_ex_is_load, id_ex_reg_wen;
  logic       ex_redirect, dmem_req, dmem_ready;
  logic       pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold;
  logic [1:0] ctrl_state;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic       mem_timeout_err;
  logic [5:0] ctrl;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_BUBL  = 6'b110010;
  localparam logic [5:0] C_FLUSH = 6'b001010;
  localparam logic [5:0] C_HOLD  = 6'b110101;

  assign ctrl = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold};

  pipe_hazard_ctrl #(.CNT_WIDTH(CW), .MEM_TIMEOUT(4), .TO_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_ex_is_load(id_ex_is_load), .id_ex_reg_wen(id_ex_reg_wen),
    .id_ex_reg_waddr(id_ex_reg_waddr), .ex_redirect(ex_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush), .ex_mem_hold(ex_mem_hold),
    .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_timeout_err(mem_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_ex_reg_waddr = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_ex_is_load = 1'b0; id_ex_reg_wen = 1'b0;
    ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic drive_load_use(input logic [4:0] waddr);
    id_ex_is_load = 1'b1; id_ex_reg_wen = 1'b1; id_ex_reg_waddr = waddr;
    id_rs1_addr = 5'd3; id_rs1_used = 1'b1;
    id_rs2_addr = waddr; id_rs2_used = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    dmem_req = 1'b1; ex_redirect = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== C_IDLE) begin tests_failed++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_IDLE); end
    tests_run++;
    if ({ctrl_state, stall_cnt, flush_cnt, mem_timeout_err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_regs: state=%0d stall=%0d flush=%0d err=%b want all 0",
               ctrl_state, stall_cnt, flush_cnt, mem_timeout_err);
    end
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    drive_load_use(5'd5);
    #1;
    tests_run++;
    if (ctrl !== C_BUBL) begin tests_failed++; $display("FAIL lu_bubble: got %b want %b", ctrl, C_BUBL); end
    tests_run++;
    if (stall_cnt !== 4'd0) begin tests_failed++; $display("FAIL lu_cnt_before: got %0d want 0", stall_cnt); end
    @(negedge clk);
    drive_idle();
    #1;
    tests_run++;
    if (ctrl !== C_IDLE) begin tests_failed++; $display("FAIL lu_one_cycle: got %b want %b", ctrl, C_IDLE); end
    tests_run++;
    if (stall_cnt !== 4'd1) begin tests_failed++; $display("FAIL lu_cnt_after: got %0d want 1", stall_cnt); end
    @(negedge clk);
    drive_load_use(5'd0);
    #1;
    tests_run++;
    if (ctrl !== C_IDLE) begin tests_failed++; $display("FAIL lu_x0: got %b want %b", ctrl, C_IDLE); end
    @(negedge clk);
    drive_load_use(5'd7);
    id_rs2_used = 1'b0;
    #1;
    tests_run++;
    if (ctrl !== C_IDLE) begin tests_failed++; $display("FAIL lu_unused_src: got %b want %b", ctrl, C_IDLE); end
    @(negedge clk);
    drive_load_use(5'd3);
    id_rs2_used = 1'b0; id_rs2_addr = 5'd9;
    #1;
    tests_run++;
    if (ctrl !== C_BUBL) begin tests_failed++; $display("FAIL lu_rs1: got %b want %b", ctrl, C_BUBL); end
    @(negedge clk);
    drive_idle();
    #1;
    tests_run++;
    if (stall_cnt !== 4'd2) begin tests_failed++; $display("FAIL lu_cnt_total: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_redirect_wins();
    do_reset();
    drive_load_use(5'd5);
    ex_redirect = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== C_FLUSH) begin tests_failed++; $display("FAIL redir_ctrl: got %b want %b", ctrl, C_FLUSH); end
    @(negedge clk);
    drive_idle();
    #1;
    tests_run++;
    if ({flush_cnt, stall_cnt} !== {4'd1, 4'd0}) begin
      tests_failed++;
      $display("FAIL redir_cnt: flush=%0d stall=%0d want flush=1 stall=0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (ctrl !== C_HOLD) begin tests_failed++; $display("FAIL mw_hold%0d: got %b want %b", i, ctrl, C_HOLD); end
      tests_run++;
      if (ctrl_state !== ((i == 0) ? 2'd0 : 2'd1)) begin
        tests_failed++;
        $display("FAIL mw_state%0d: got %0d want %0d", i, ctrl_state, (i == 0) ? 0 : 1);
      end
      @(negedge clk);
    end
    dmem_ready = 1'b1; ex_redirect = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== C_FLUSH) begin tests_failed++; $display("FAIL mw_release_redir: got %b want %b", ctrl, C_FLUSH); end
    @(negedge clk);
    drive_idle();
    #1;
    tests_run++;
    if ({ctrl_state, stall_cnt, flush_cnt} !== {2'd0, 4'd3, 4'd1}) begin
      tests_failed++;
      $display("FAIL mw_end: state=%0d stall=%0d flush=%0d want 0/3/1", ctrl_state, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if ({ctrl, mem_timeout_err} !== {C_HOLD, 1'b0}) begin
        tests_failed++;
        $display("FAIL to_wait%0d: ctrl=%b err=%b want %b/0", i, ctrl, mem_timeout_err, C_HOLD);
      end
      @(negedge clk);
    end
    dmem_req = 1'b0;
    #1;
    tests_run++;
    if ({ctrl_state, ctrl, mem_timeout_err} !== {2'd2, C_FLUSH, 1'b1}) begin
      tests_failed++;
      $display("FAIL to_abort: state=%0d ctrl=%b err=%b want 2/%b/1", ctrl_state, ctrl, mem_timeout_err, C_FLUSH);
    end
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      tests_run++;
      if ({ctrl_state, ctrl, mem_timeout_err} !== {2'd0, C_IDLE, 1'b1}) begin
        tests_failed++;
        $display("FAIL to_sticky%0d: state=%0d ctrl=%b err=%b want 0/0/1", i, ctrl_state, ctrl, mem_timeout_err);
      end
      @(negedge clk);
    end
    tests_run++;
    if ({stall_cnt, flush_cnt} !== {4'd5, 4'd1}) begin
      tests_failed++;
      $display("FAIL to_cnt: stall=%0d flush=%0d want 5/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (ctrl_state !== 2'd1) begin tests_failed++; $display("FAIL ar_in_wait: got %0d want 1", ctrl_state); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({ctrl_state, ctrl, stall_cnt} !== {2'd0, C_IDLE, 4'd0}) begin
      tests_failed++;
      $display("FAIL ar_immediate: state=%0d ctrl=%b stall=%0d want 0/0/0", ctrl_state, ctrl, stall_cnt);
    end
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if ({ctrl_state, ctrl, stall_cnt, flush_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL ar_release: state=%0d ctrl=%b stall=%0d flush=%0d want all 0",
               ctrl_state, ctrl, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [CW-1:0] exp_cnt;
    do_reset();
    exp_cnt = '0;
    drive_load_use(5'd12);
    for (int i = 0; i < 20; i++) begin
      #1;
      tests_run++;
      if (stall_cnt !== exp_cnt) begin tests_failed++; $display("FAIL sat_step%0d: got %0d want %0d", i, stall_cnt, exp_cnt); end
      if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 1'b1;
      @(negedge clk);
    end
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (stall_cnt !== 4'd15) begin tests_failed++; $display("FAIL sat_hold%0d: got %0d want 15", i, stall_cnt); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect_wins();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
